// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU memory path: access sizes and the data memory
// unit state machine.
package cpu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_IDLE  = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } dmu_state_t;

endpackage

// File: rtl/dmu_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Each byte lane owns its own array so the tools can map it onto block RAM.
module dmu_ram #(
    parameter int WORDS = 64,
    parameter int IW    = 6
) (
    input  logic          Clk,
    input  logic [IW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [WORDS];
        logic [7:0] lane_rd;

        always_ff @(posedge Clk) begin
            if (we[gi]) begin
                lane_mem[addr] <= wdata[gi*8 +: 8];
            end
            lane_rd <= lane_mem[addr];
        end

        assign rdata[gi*8 +: 8] = lane_rd;
    end

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressed little-endian data memory with a req/ack handshake, optional
// wait states and a post-reset clear sequence.
module data_memory_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH_BYTES    = 256,
    parameter int WAIT_STATES    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        MemWr,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Ad,
    input  logic [31:0] WrData,
    output logic        Ready,
    output logic        Ack,
    output logic [31:0] DM,
    output logic        Misalign,
    output logic        Busy
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int IW    = AW - 2;
    localparam int WORDS = DEPTH_BYTES / 4;

    dmu_state_t     state_q, state_d;
    logic [IW-1:0]  clr_idx_q, clr_idx_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    logic           cap_wr_q, cap_wr_d;
    logic [1:0]     cap_size_q, cap_size_d;
    logic           cap_uns_q, cap_uns_d;
    logic [AW-1:0]  cap_ad_q, cap_ad_d;
    logic [31:0]    cap_wdata_q, cap_wdata_d;
    logic           cap_mis_q, cap_mis_d;
    logic [31:0]    dm_q, dm_d;

    logic [IW-1:0]  ram_addr;
    logic [3:0]     ram_we;
    logic [31:0]    ram_wdata;
    logic [31:0]    ram_rdata;
    logic           mis_in;
    logic [3:0]     store_be;
    logic [31:0]    store_data;
    logic [31:0]    load_val;
    logic [31:0]    rd_shift;
    logic           unused_ad_hi;

    // Upper address bits alias onto the array.
    assign unused_ad_hi = ^Ad[31:AW];

    always_comb begin
        mis_in = 1'b0;
        case (Size)
            SIZE_HALF: mis_in = Ad[0];
            SIZE_WORD: mis_in = (Ad[1:0] != 2'b00);
            SIZE_RSVD: mis_in = 1'b1;
            default:   mis_in = 1'b0;
        endcase
    end

    // Lane steering for stores and extension for loads, from captured operands.
    always_comb begin
        store_be   = 4'b0000;
        store_data = cap_wdata_q;
        load_val   = ram_rdata;
        rd_shift   = ram_rdata >> {cap_ad_q[1:0], 3'b000};
        case (cap_size_q)
            SIZE_BYTE: begin
                store_be   = 4'b0001 << cap_ad_q[1:0];
                store_data = {4{cap_wdata_q[7:0]}};
                load_val   = cap_uns_q ? {24'h0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
            end
            SIZE_HALF: begin
                store_be   = cap_ad_q[1] ? 4'b1100 : 4'b0011;
                store_data = {2{cap_wdata_q[15:0]}};
                load_val   = cap_uns_q ? {16'h0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
            end
            SIZE_WORD: begin
                store_be   = 4'b1111;
                store_data = cap_wdata_q;
                load_val   = ram_rdata;
            end
            default: begin
                store_be   = 4'b0000;
                store_data = cap_wdata_q;
                load_val   = ram_rdata;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        wait_cnt_d  = wait_cnt_q;
        cap_wr_d    = cap_wr_q;
        cap_size_d  = cap_size_q;
        cap_uns_d   = cap_uns_q;
        cap_ad_d    = cap_ad_q;
        cap_wdata_d = cap_wdata_q;
        cap_mis_d   = cap_mis_q;
        dm_d        = dm_q;
        ram_addr    = cap_ad_q[AW-1:2];
        ram_we      = 4'b0000;
        ram_wdata   = 32'h0;
        case (state_q)
            ST_CLEAR: begin
                ram_addr  = clr_idx_q;
                ram_we    = 4'b1111;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IW'(WORDS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Read speculatively at the live address so data is ready even with no wait states.
                ram_addr = Ad[AW-1:2];
                if (Req) begin
                    cap_wr_d    = MemWr;
                    cap_size_d  = Size;
                    cap_uns_d   = Unsigned;
                    cap_ad_d    = Ad[AW-1:0];
                    cap_wdata_d = WrData;
                    cap_mis_d   = mis_in;
                    if (mis_in || WAIT_STATES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - 1'b1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!cap_mis_q) begin
                    if (cap_wr_q) begin
                        ram_we    = store_be;
                        ram_wdata = store_data;
                    end else begin
                        dm_d = load_val;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_idx_q   <= '0;
            wait_cnt_q  <= '0;
            cap_wr_q    <= 1'b0;
            cap_size_q  <= SIZE_BYTE;
            cap_uns_q   <= 1'b0;
            cap_ad_q    <= '0;
            cap_wdata_q <= '0;
            cap_mis_q   <= 1'b0;
            dm_q        <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            wait_cnt_q  <= wait_cnt_d;
            cap_wr_q    <= cap_wr_d;
            cap_size_q  <= cap_size_d;
            cap_uns_q   <= cap_uns_d;
            cap_ad_q    <= cap_ad_d;
            cap_wdata_q <= cap_wdata_d;
            cap_mis_q   <= cap_mis_d;
            dm_q        <= dm_d;
        end
    end

    dmu_ram #(
        .WORDS (WORDS),
        .IW    (IW)
    ) u_ram (
        .Clk   (Clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign Ready    = (state_q == ST_IDLE);
    assign Ack      = (state_q == ST_DONE);
    assign Busy     = (state_q == ST_CLEAR);
    assign Misalign = Ack && cap_mis_q;
    // During a load Ack the result comes straight off the RAM output register; dm_q holds it after.
    assign DM       = (Ack && !cap_wr_q && !cap_mis_q) ? load_val : dm_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: clear sequence, lane steering, extension,
// wait-state latency, misalignment and mid-operation reset.
module tb_data_memory_unit;

    localparam int DEPTH = 256;
    localparam int WS    = 3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic        MemWr = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Unsigned = 1'b0;
    logic [31:0] Ad = 32'h0;
    logic [31:0] WrData = 32'h0;
    logic        Ready, Ack, Misalign, Busy;
    logic [31:0] DM;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_dm = 32'h0;

    always #5 Clk = ~Clk;

    data_memory_unit #(
        .DEPTH_BYTES    (DEPTH),
        .WAIT_STATES    (WS),
        .CLEAR_ON_RESET (1)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .MemWr    (MemWr),
        .Size     (Size),
        .Unsigned (Unsigned),
        .Ad       (Ad),
        .WrData   (WrData),
        .Ready    (Ready),
        .Ack      (Ack),
        .DM       (DM),
        .Misalign (Misalign),
        .Busy     (Busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (Busy && n < 500) begin
            n++;
            @(negedge Clk);
        end
        check({tag, "_busy_cycles"}, n, DEPTH / 4);
        check({tag, "_ready_after"}, 32'(Ready), 32'd1);
        $display("clear %s: busy for %0d cycles", tag, n);
    endtask

    task automatic access(input string tag, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] ad, input logic [31:0] wd, input bit exp_mis,
                          input logic [31:0] exp_dm, input bit hold);
        int n;
        int lat;
        int rhigh;
        logic [31:0] dmv;
        logic mis;
        n = 0;
        while (!Ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!Ready) check({tag, "_ready_timeout"}, 32'(Ready), 32'd1);
        Req = 1'b1; MemWr = wr; Size = sz; Unsigned = uns; Ad = ad; WrData = wd;
        @(posedge Clk);
        #1;
        if (!hold) Req = 1'b0;
        Ad = ~ad; WrData = ~wd; Size = ~sz; Unsigned = ~uns; MemWr = ~wr;
        lat = 0; rhigh = 0; dmv = 32'h0; mis = 1'b0;
        while (lat < 40) begin
            @(negedge Clk);
            lat++;
            if (Ack) begin
                dmv = DM;
                mis = Misalign;
                break;
            end
            if (Ready) rhigh++;
        end
        if (!Ack) check({tag, "_ack_timeout"}, 32'(Ack), 32'd1);
        Req = 1'b0;
        check({tag, "_lat"}, lat, exp_mis ? 1 : WS + 1);
        check({tag, "_mis"}, 32'(mis), 32'(exp_mis));
        check({tag, "_ready_busy"}, rhigh, 0);
        if (wr || exp_mis) check({tag, "_dm_hold"}, dmv, last_dm);
        else begin
            check({tag, "_dm"}, dmv, exp_dm);
            last_dm = exp_dm;
        end
        $display("xact %s: wr=%0d size=%0d uns=%0d ad=%h wd=%h lat=%0d dm=%h mis=%0d",
                 tag, wr, sz, uns, ad, wd, lat, dmv, mis);
        @(negedge Clk);
        check({tag, "_ack_pulse"}, 32'(Ack), 32'd0);
        check({tag, "_ready_next"}, 32'(Ready), 32'd1);
        check({tag, "_dm_after"}, DM, last_dm);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_busy", 32'(Busy), 32'd1);
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_ack", 32'(Ack), 32'd0);
        check("rst_dm", DM, 32'h0);
        check("rst_mis", 32'(Misalign), 32'd0);
        Reset = 1'b0;
        wait_clear("por");

        access("ld_fc",   0, SZ_W, 0, 32'h0FC, 32'h0,        0, 32'h00000000, 0);
        access("st_10",   1, SZ_W, 0, 32'h010, 32'h812345F6, 0, 32'h0,        0);
        access("lbs_10",  0, SZ_B, 0, 32'h010, 32'h0,        0, 32'hFFFFFFF6, 0);
        access("lbs_13",  0, SZ_B, 0, 32'h013, 32'h0,        0, 32'hFFFFFF81, 0);
        access("lbu_10",  0, SZ_B, 1, 32'h010, 32'h0,        0, 32'h000000F6, 0);
        access("lbu_13",  0, SZ_B, 1, 32'h013, 32'h0,        0, 32'h00000081, 0);
        access("sb_11",   1, SZ_B, 0, 32'h011, 32'hAAAA557E, 0, 32'h0,        0);
        access("lw_10",   0, SZ_W, 0, 32'h010, 32'h0,        0, 32'h81237EF6, 0);
        access("st_20",   1, SZ_W, 0, 32'h020, 32'h11223344, 0, 32'h0,        0);
        access("sh_22",   1, SZ_H, 0, 32'h022, 32'h5555BEEF, 0, 32'h0,        0);
        access("lw_20",   0, SZ_W, 0, 32'h020, 32'h0,        0, 32'hBEEF3344, 0);
        access("lhs_22",  0, SZ_H, 0, 32'h022, 32'h0,        0, 32'hFFFFBEEF, 0);
        access("lhu_20",  0, SZ_H, 1, 32'h020, 32'h0,        0, 32'h00003344, 0);

        access("hold_10", 0, SZ_W, 0, 32'h010, 32'h0,        0, 32'h81237EF6, 1);
        @(negedge Clk);
        check("hold_no_reaccept", 32'(Ack), 32'd0);

        access("mis_sw06", 1, SZ_W, 0, 32'h006, 32'hDEADBEEF, 1, 32'h0, 0);
        access("mis_lh03", 0, SZ_H, 0, 32'h003, 32'h0,        1, 32'h0, 0);
        access("mis_lr20", 0, SZ_R, 0, 32'h020, 32'h0,        1, 32'h0, 0);
        access("mis_sr20", 1, SZ_R, 0, 32'h020, 32'hCAFEF00D, 1, 32'h0, 0);
        access("lw_04",    0, SZ_W, 0, 32'h004, 32'h0,        0, 32'h00000000, 0);
        access("lw_20b",   0, SZ_W, 0, 32'h020, 32'h0,        0, 32'hBEEF3344, 0);

        access("st_140",  1, SZ_W, 0, 32'h140, 32'h55AA1234, 0, 32'h0,        0);
        access("lw_40",   0, SZ_W, 0, 32'h040, 32'h0,        0, 32'h55AA1234, 0);

        // Store accepted, then reset lands in its first wait cycle.
        Req = 1'b1; MemWr = 1'b1; Size = SZ_W; Unsigned = 1'b0; Ad = 32'h40; WrData = 32'hCAFEBABE;
        @(posedge Clk);
        #1 Req = 1'b0;
        @(negedge Clk);
        check("mid_ack_wait", 32'(Ack), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        check("mid_ack_rst", 32'(Ack), 32'd0);
        check("mid_busy_rst", 32'(Busy), 32'd1);
        check("mid_ready_rst", 32'(Ready), 32'd0);
        check("mid_dm_rst", DM, 32'h0);
        last_dm = 32'h0;
        Reset = 1'b0;
        $display("xact mid_reset: store to 040 abandoned");
        wait_clear("mid");
        access("lw_40_clr",  0, SZ_W, 0, 32'h040, 32'h0, 0, 32'h00000000, 0);
        access("lw_140_clr", 0, SZ_W, 0, 32'h140, 32'h0, 0, 32'h00000000, 0);
        access("lw_10_clr",  0, SZ_W, 0, 32'h010, 32'h0, 0, 32'h00000000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
